// File: rtl/lpf_decimator.sv
// Decimates the complex LPF output by DECIM, then rounds, shifts and saturates it to OUT_W bits into a small valid/ready FIFO.
// Optional per-event statistics counters are built when LPF_DEC_STATS_EN is defined.
module lpf_decimator #(
    parameter int IN_W       = 62,
    parameter int OUT_W      = 16,
    parameter int DECIM      = 8,
    parameter int SHIFT      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_real,
    input  logic signed [IN_W-1:0]  in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_real,
    output logic signed [OUT_W-1:0] out_imag,
    output logic                    saturated,
    output logic                    overflow,
    output logic [15:0]             sat_cnt,
    output logic [15:0]             drop_cnt
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam logic [PH_W-1:0]       PH_LAST = PH_W'(DECIM - 1);
    localparam logic [CW-1:0]         CNT_MAX = CW'(FIFO_DEPTH);
    localparam logic signed [IN_W:0]  RND     = (SHIFT > 0) ? ((IN_W+1)'(1) <<< (SHIFT - 1)) : '0;
    localparam logic signed [IN_W:0]  SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0]  SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]         r_phase;
    logic                    r_s1_valid;
    logic signed [IN_W:0]    r_s1_re;
    logic signed [IN_W:0]    r_s1_im;
    logic signed [OUT_W-1:0] r_mem_re [FIFO_DEPTH];
    logic signed [OUT_W-1:0] r_mem_im [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_out_valid;
    logic                    r_saturated;
    logic                    r_overflow;

    logic                    w_keep;
    logic signed [IN_W:0]    w_ext_re;
    logic signed [IN_W:0]    w_ext_im;
    logic signed [IN_W:0]    w_rnd_re;
    logic signed [IN_W:0]    w_rnd_im;
    logic signed [OUT_W-1:0] w_clamp_re;
    logic signed [OUT_W-1:0] w_clamp_im;
    logic                    w_clip;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [CW-1:0]           w_count_nxt;

    assign w_keep   = in_valid && (r_phase == '0);
    assign w_ext_re = {in_real[IN_W-1], in_real};
    assign w_ext_im = {in_imag[IN_W-1], in_imag};
    assign w_rnd_re = (w_ext_re + RND) >>> SHIFT;
    assign w_rnd_im = (w_ext_im + RND) >>> SHIFT;

    // Decimation phase and the rounded/shifted stage-1 sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
        end else begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_re <= w_rnd_re;
                r_s1_im <= w_rnd_im;
            end
            if (in_valid) begin
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
            end
        end
    end

    // Saturate stage-1 to the output range and decide the FIFO write
    always_comb begin
        w_clamp_re = r_s1_re[OUT_W-1:0];
        w_clamp_im = r_s1_im[OUT_W-1:0];
        w_clip     = 1'b0;
        if (r_s1_re > SAT_MAX) begin
            w_clamp_re = OUT_MAX;
            w_clip     = 1'b1;
        end else if (r_s1_re < SAT_MIN) begin
            w_clamp_re = OUT_MIN;
            w_clip     = 1'b1;
        end else begin
            w_clamp_re = r_s1_re[OUT_W-1:0];
        end
        if (r_s1_im > SAT_MAX) begin
            w_clamp_im = OUT_MAX;
            w_clip     = 1'b1;
        end else if (r_s1_im < SAT_MIN) begin
            w_clamp_im = OUT_MIN;
            w_clip     = 1'b1;
        end else begin
            w_clamp_im = r_s1_im[OUT_W-1:0];
        end
        w_pop       = r_out_valid && out_ready;
        w_push      = r_s1_valid && ((r_count != CNT_MAX) || w_pop);
        w_drop      = r_s1_valid && !w_push;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    // Output FIFO storage, pointers, occupancy and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_re[i] <= '0;
                r_mem_im[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_saturated <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_re[r_wr_ptr] <= w_clamp_re;
                r_mem_im[r_wr_ptr] <= w_clamp_im;
                r_wr_ptr           <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_saturated <= r_saturated || (r_s1_valid && w_clip);
            r_overflow  <= r_overflow || w_drop;
        end
    end

    assign out_valid = r_out_valid;
    assign out_real  = r_mem_re[r_rd_ptr];
    assign out_imag  = r_mem_im[r_rd_ptr];
    assign saturated = r_saturated;
    assign overflow  = r_overflow;

`ifdef LPF_DEC_STATS_EN
    logic [15:0] r_sat_cnt;
    logic [15:0] r_drop_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (r_s1_valid && w_clip && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign sat_cnt  = r_sat_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    assign sat_cnt  = 16'd0;
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lpf_decimator.sv
// Directed + random bench for lpf_decimator against a queue-based reference model.
module tb_lpf_decimator;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [61:0] in_real;
    logic signed [61:0] in_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_real;
    logic signed [15:0] out_imag;
    logic               saturated;
    logic               overflow;
    logic [15:0]        sat_cnt;
    logic [15:0]        drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    longint q_re[$];
    longint q_im[$];
    bit     pend_v;
    longint pend_re;
    longint pend_im;
    bit     pend_sat;
    int     m_phase;
    bit     m_sat;
    bit     m_ovf;
    int     m_satc;
    int     m_dropc;

    lpf_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .saturated (saturated),
        .overflow  (overflow),
        .sat_cnt   (sat_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round half up by 2^14, then clamp to 16-bit signed.
    function automatic longint scale(input longint x, output bit clip);
        longint r;
        r    = (x + 64'sd8192) >>> 14;
        clip = 1'b0;
        if (r > 64'sd32767) begin
            r    = 64'sd32767;
            clip = 1'b1;
        end else if (r < -64'sd32768) begin
            r    = -64'sd32768;
            clip = 1'b1;
        end
        return r;
    endfunction

    task automatic step(input bit rst, input bit v, input longint re, input longint im, input bit rdy);
        bit     pop;
        bit     c_re;
        bit     c_im;
        reset     = rst;
        in_valid  = v;
        in_real   = re[61:0];
        in_imag   = im[61:0];
        out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            q_re.delete();
            q_im.delete();
            pend_v  = 1'b0;
            m_phase = 0;
            m_sat   = 1'b0;
            m_ovf   = 1'b0;
            m_satc  = 0;
            m_dropc = 0;
        end else begin
            pop = (q_re.size() != 0) && rdy;
            if (pop) begin
                void'(q_re.pop_front());
                void'(q_im.pop_front());
            end
            if (pend_v) begin
                if (q_re.size() < 4) begin
                    q_re.push_back(pend_re);
                    q_im.push_back(pend_im);
                end else begin
                    m_ovf = 1'b1;
                    if (m_dropc < 65535) m_dropc++;
                end
                if (pend_sat) begin
                    m_sat = 1'b1;
                    if (m_satc < 65535) m_satc++;
                end
            end
            pend_v = v && (m_phase == 0);
            if (pend_v) begin
                pend_re  = scale(re, c_re);
                pend_im  = scale(im, c_im);
                pend_sat = c_re || c_im;
            end
            if (v) m_phase = (m_phase + 1) % 8;
        end
        #1;
        chk("out_valid", out_valid, (q_re.size() != 0));
        if (q_re.size() != 0) begin
            chk("out_real", out_real, q_re[0]);
            chk("out_imag", out_imag, q_im[0]);
        end
        chk("saturated", saturated, m_sat);
        chk("overflow", overflow, m_ovf);
`ifdef LPF_DEC_STATS_EN
        chk("sat_cnt", sat_cnt, m_satc);
        chk("drop_cnt", drop_cnt, m_dropc);
`else
        chk("sat_cnt", sat_cnt, 0);
        chk("drop_cnt", drop_cnt, 0);
`endif
    endtask

    initial begin
        longint rvals[5];
        longint rexp[5];
        longint a;
        longint b;
        int     mode;
        clk       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;
        pend_v    = 1'b0;
        rvals = '{64'sd8192, 64'sd8191, -64'sd8192, -64'sd8193, 64'sd24576};
        rexp  = '{64'sd1, 64'sd0, 64'sd0, -64'sd1, 64'sd2};

        // Reset state
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);

        // Continuous input, constant +/-49152
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 64'sd49152, -64'sd49152, 1'b1);
            if (i == 0) chk("first_lat0", out_valid, 0);
            if (i == 1) begin
                chk("first_lat1", out_valid, 1);
                chk("const_re", out_real, 3);
                chk("const_im", out_imag, -3);
            end
        end

        // Rounding boundaries
        for (int g = 0; g < 5; g++) begin
            for (int j = 0; j < 8; j++) begin
                step(1'b0, 1'b1, rvals[g], -rvals[g], 1'b1);
                if (j == 1) chk("round", out_real, rexp[g]);
            end
        end
        chk("round_nosat", saturated, 0);

        // Saturation
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 1'b1, 64'sd1 <<< 40, -(64'sd1 <<< 40), 1'b1);
            if (j == 1) begin
                chk("sat_re", out_real, 32767);
                chk("sat_im", out_imag, -32768);
                chk("sat_flag", saturated, 1);
            end
        end

        // Backpressure with five decimated samples
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            a = longint'(i / 8 + 1) * 64'sd16384;
            step(1'b0, 1'b1, a, -a, 1'b0);
        end
        chk("bp_head", out_real, 1);
        chk("bp_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", out_real, i + 1);
            step(1'b0, 1'b0, 0, 0, 1'b1);
        end
        chk("bp_empty", out_valid, 0);

        // Full FIFO popped on the edge a new sample arrives
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 34; i++) begin
            a = longint'(i / 8 + 1) * 64'sd16384;
            step(1'b0, 1'b1, a, -a, (i == 33));
        end
        chk("full_pop_ovf", overflow, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 0, 1'b1);

        // Reset with buffered entries and a stage-1 sample in flight
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 64'sd16384, 64'sd16384, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("midrst_valid", out_valid, 0);
        step(1'b0, 1'b1, 64'sd81920, -64'sd81920, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b0);
        chk("midrst_valid2", out_valid, 1);
        chk("midrst_re", out_real, 5);

        // Random traffic
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            mode = $urandom_range(0, 2);
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            if (mode == 0) begin
                a = a >>> 2;
                b = b >>> 2;
            end else if (mode == 1) begin
                a = a >>> 30;
                b = b >>> 30;
            end else begin
                a = a >>> 44;
                b = b >>> 44;
            end
            step(1'b0, ($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
